// File: rtl/ldc_bank.sv
// Bank of gated hold registers with sticky change flags and an atomic four-phase snapshot port.
// Define LDC_TRANSPARENT_EN to make Q a combinational bypass of the pending load or clear.
module ldc_bank #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter logic        INIT     = 1'b0
) (
   input  logic                        C,
   input  logic                        R,
   input  logic [CHANNELS-1:0]         CLR,
   input  logic [CHANNELS-1:0]         G,
   input  logic [CHANNELS*WIDTH-1:0]   D,
   output logic [CHANNELS*WIDTH-1:0]   Q,
   output logic [CHANNELS-1:0]         UPD,
   input  logic                        SNAP_REQ,
   output logic                        SNAP_ACK,
   output logic [CHANNELS*WIDTH-1:0]   SNAP_Q,
   output logic [CHANNELS-1:0]         SNAP_UPD
);

   localparam int unsigned N = WIDTH * CHANNELS;

   typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

   state_e              state_q, state_d;
   logic [N-1:0]        stored_q, stored_d;
   logic [N-1:0]        snap_q_q, snap_q_d;
   logic [CHANNELS-1:0] upd_q, upd_d;
   logic [CHANNELS-1:0] snap_upd_q, snap_upd_d;
   logic [CHANNELS-1:0] changed;
   logic                ack_q, ack_d;

   always_comb begin
      stored_d = stored_q;
      changed  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (CLR[i]) begin
            stored_d[i*WIDTH +: WIDTH] = '0;
         end else if (G[i]) begin
            stored_d[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
         end
         changed[i] = (stored_d[i*WIDTH +: WIDTH] != stored_q[i*WIDTH +: WIDTH]);
      end
   end

   always_comb begin
      state_d    = state_q;
      snap_q_d   = snap_q_q;
      snap_upd_d = snap_upd_q;
      upd_d      = upd_q | changed;
      unique case (state_q)
         StIdle: begin
            if (SNAP_REQ) state_d = StCapture;
         end
         StCapture: begin
            // Capture pre-edge contents; a change on this very edge re-arms its flag.
            snap_q_d   = stored_q;
            snap_upd_d = upd_q;
            upd_d      = changed;
            state_d    = StHold;
         end
         StHold: begin
            if (!SNAP_REQ) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      ack_d = (state_d == StHold);
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_q    <= StIdle;
         stored_q   <= {N{INIT}};
         snap_q_q   <= '0;
         upd_q      <= '0;
         snap_upd_q <= '0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         stored_q   <= stored_d;
         snap_q_q   <= snap_q_d;
         upd_q      <= upd_d;
         snap_upd_q <= snap_upd_d;
         ack_q      <= ack_d;
      end
   end

`ifdef LDC_TRANSPARENT_EN
   assign Q = stored_d;
`else
   assign Q = stored_q;
`endif
   assign UPD      = upd_q;
   assign SNAP_ACK = ack_q;
   assign SNAP_Q   = snap_q_q;
   assign SNAP_UPD = snap_upd_q;

endmodule

// File: tb/tb_ldc_bank.sv
// Scoreboard bench for ldc_bank: driver feeds a per-channel reference model, monitor compares.
module tb_ldc_bank;

   localparam int W  = 8;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            r = 1'b0;
   logic [CH-1:0]   clr = '0, g = '0;
   logic [CH*W-1:0] d = '0;
   logic            req = 1'b0;
   logic [CH*W-1:0] q, snap_q;
   logic [CH-1:0]   upd, snap_upd;
   logic            ack;

   int n_checks = 0;
   int n_err    = 0;

   ldc_bank #(.WIDTH(W), .CHANNELS(CH), .INIT(1'b1)) dut (
      .C(clk), .R(r), .CLR(clr), .G(g), .D(d), .Q(q), .UPD(upd),
      .SNAP_REQ(req), .SNAP_ACK(ack), .SNAP_Q(snap_q), .SNAP_UPD(snap_upd)
   );

   always #5 clk = ~clk;

   // Reference model: plain per-channel values and snapshot bookkeeping.
   logic [W-1:0]  m_ch [CH];
   logic [W-1:0]  m_snap [CH];
   logic [CH-1:0] m_upd = '0, m_snap_upd = '0;
   bit            m_ack = 0, m_pend = 0, m_valid = 0;

   typedef struct {
      logic [CH*W-1:0] q;
      logic [CH-1:0]   upd;
      logic            ack;
      logic [CH*W-1:0] sq;
      logic [CH-1:0]   su;
   } exp_t;
   typedef struct {
      logic [CH*W-1:0] sq;
      logic [CH-1:0]   su;
   } snap_t;

   exp_t  cyc_exp[$];
   snap_t snap_exp[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CH*W-1:0] pack_snap();
      logic [CH*W-1:0] v;
      for (int i = 0; i < CH; i++) v[i*W +: W] = m_snap[i];
      return v;
   endfunction

   task automatic push_expect();
      exp_t e;
      for (int i = 0; i < CH; i++) begin
`ifdef LDC_TRANSPARENT_EN
         e.q[i*W +: W] = clr[i] ? '0 : g[i] ? d[i*W +: W] : m_ch[i];
`else
         e.q[i*W +: W] = m_ch[i];
`endif
      end
      e.upd = m_upd;
      e.ack = m_ack;
      e.sq  = pack_snap();
      e.su  = m_snap_upd;
      cyc_exp.push_back(e);
   endtask

   task automatic model_edge();
      logic [W-1:0]  nv [CH];
      logic [CH-1:0] chg;
      snap_t         s;
      if (r) begin
         for (int i = 0; i < CH; i++) begin
            m_ch[i]   = '1;
            m_snap[i] = '0;
         end
         m_upd = '0; m_snap_upd = '0; m_ack = 0; m_pend = 0; m_valid = 1;
         return;
      end
      for (int i = 0; i < CH; i++) begin
         nv[i]  = clr[i] ? '0 : g[i] ? d[i*W +: W] : m_ch[i];
         chg[i] = (nv[i] != m_ch[i]);
      end
      if (m_pend) begin
         for (int i = 0; i < CH; i++) m_snap[i] = m_ch[i];
         m_snap_upd = m_upd;
         m_upd      = chg;
         m_pend     = 0;
         m_ack      = 1;
         s.sq = pack_snap();
         s.su = m_snap_upd;
         snap_exp.push_back(s);
      end else begin
         m_upd = m_upd | chg;
         if (m_ack && !req) m_ack = 0;
         else if (!m_ack && req) m_pend = 1;
      end
      for (int i = 0; i < CH; i++) m_ch[i] = nv[i];
   endtask

   task automatic apply(input logic ri, input logic [CH-1:0] ci, input logic [CH-1:0] gi,
                        input logic [CH*W-1:0] di, input logic qi);
      r = ri; clr = ci; g = gi; d = di; req = qi;
      if (m_valid) push_expect();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Monitor: one expected output set per cycle, plus a snapshot record per SNAP_ACK rise.
   logic  ack_prev = 1'b0;
   exp_t  e_mon;
   snap_t s_mon;
   always @(negedge clk) begin
      if (cyc_exp.size() > 0) begin
         e_mon = cyc_exp.pop_front();
         check("q", 64'(q), 64'(e_mon.q));
         check("upd", 64'(upd), 64'(e_mon.upd));
         check("snap_ack", 64'(ack), 64'(e_mon.ack));
         check("snap_q", 64'(snap_q), 64'(e_mon.sq));
         check("snap_upd", 64'(snap_upd), 64'(e_mon.su));
      end
      if (ack === 1'b1 && ack_prev !== 1'b1) begin
         if (snap_exp.size() == 0) begin
            check("snap_unexpected_ack", 64'(ack), 64'd0);
         end else begin
            s_mon = snap_exp.pop_front();
            check("snapshot_q", 64'(snap_q), 64'(s_mon.sq));
            check("snapshot_upd", 64'(snap_upd), 64'(s_mon.su));
         end
      end
      ack_prev = ack;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0]   cc, gg;
      logic [CH*W-1:0] dd;
      logic            rq;

      // 1) reset with INIT=1
      apply(1, '0, '0, '0, 0);
      check("reset_q", 64'(q), 64'hFFFF_FFFF);
      check("reset_upd", 64'(upd), 64'd0);
      check("reset_ack", 64'(ack), 64'd0);

      // 2) load then hold
      apply(0, '0, 4'b0001, 32'h0000_00A5, 0);
      apply(0, '0, 4'b0000, 32'h0000_003C, 0);
      check("hold_q0", 64'(q[7:0]), 64'hA5);
      check("hold_upd", 64'(upd), 64'b0001);

      // 3) clear beats gate
      apply(0, 4'b0010, 4'b0010, 32'h0000_FF00, 0);
      check("clr_wins_q1", 64'(q[15:8]), 64'h00);

      // 4) snapshot of channel 2
      apply(0, '0, 4'b0100, 32'h0011_0000, 0);
      apply(0, 4'b1000, '0, '0, 0);
      apply(0, '0, '0, '0, 1);
      check("ack_not_yet", 64'(ack), 64'd0);
      apply(0, '0, '0, '0, 1);
      check("ack_two_edges", 64'(ack), 64'd1);
      check("snap_q2", 64'(snap_q[23:16]), 64'h11);
      check("snap_upd_prior", 64'(snap_upd), 64'b1111);
      check("upd_cleared", 64'(upd), 64'd0);
      apply(0, '0, '0, '0, 0);
      check("ack_drop", 64'(ack), 64'd0);

      // 5) load on the capture edge
      apply(0, '0, '0, '0, 1);
      apply(0, '0, 4'b1000, 32'h2200_0000, 1);
      check("cap_snap_q3", 64'(snap_q[31:24]), 64'h00);
      check("cap_snap_upd3", 64'(snap_upd[3]), 64'd0);
      check("cap_upd3_set", 64'(upd[3]), 64'd1);

      // 6) reset during HOLD
      apply(0, '0, '0, '0, 1);
      apply(1, '0, '0, '0, 1);
      check("rst_hold_ack", 64'(ack), 64'd0);
      check("rst_hold_snap_q", 64'(snap_q), 64'd0);
      check("rst_hold_q", 64'(q), 64'hFFFF_FFFF);
      apply(0, '0, '0, '0, 0);
      apply(0, '0, '0, '0, 0);

      // Transparent bypass, observed before the edge.
      r = 0; clr = '0; g = 4'b0001; d = 32'h0000_005A; req = 0;
      #1;
`ifdef LDC_TRANSPARENT_EN
      check("bypass_q0", 64'(q[7:0]), 64'h5A);
`else
      check("registered_q0", 64'(q[7:0]), 64'hFF);
`endif
      apply(0, '0, 4'b0001, 32'h0000_005A, 0);
      check("loaded_q0", 64'(q[7:0]), 64'h5A);

      // Randomized traffic
      rq = 0;
      for (int n = 0; n < 500; n++) begin
         dd = {$urandom};
         for (int i = 0; i < CH; i++) begin
            cc[i] = ($urandom_range(0, 9) == 0);
            gg[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) dd[i*W +: W] = m_ch[i];
         end
         if ($urandom_range(0, 4) == 0) rq = ~rq;
         apply(($urandom_range(0, 59) == 0), cc, gg, dd, rq);
      end
      apply(0, '0, '0, '0, 0);
      apply(0, '0, '0, '0, 0);
      @(negedge clk);
      #1;
      check("snap_queue_drained", 64'(snap_exp.size()), 64'd0);
      check("cycle_queue_drained", 64'(cyc_exp.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
